// File: rtl/ks_control_mc.sv
// Multi-cycle control FSM: fetch/decode/execute sequencing with optional
// performance counters enabled by defining KS_CTRL_PERF_CNT_EN.
module ks_control_mc #(
  parameter int OP_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       instr_class,
  input  logic [OP_W-1:0]  instr_alu_op,
  input  logic [3:0]       instr_cond,
  input  logic             zero,
  input  logic             neg,
  input  logic             unsigned_overflow,
  input  logic             signed_overflow,
  input  logic             mem_ready,
  output logic             branch,
  output logic             pc_enable,
  output logic             ir_enable,
  output logic             addr_sel,
  output logic             c_sel,
  output logic             write_reg_enable,
  output logic [OP_W-1:0]  operation,
  output logic             halt,
  output logic             write_enable,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] MEM_RD  = 3'd3;
  localparam logic [2:0] MEM_WR  = 3'd4;
  localparam logic [2:0] BRANCH  = 3'd5;
  localparam logic [2:0] HALTED  = 3'd6;

  logic [2:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  logic            branch_c, pc_enable_c, ir_enable_c, addr_sel_c, c_sel_c;
  logic            write_reg_enable_c, halt_c, write_enable_c;
  logic [OP_W-1:0] operation_c;

  function automatic logic cond_taken(input logic [3:0] c, input logic z,
                                      input logic n, input logic u,
                                      input logic s);
    case (c)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return n;
      4'd4:    return !n;
      4'd5:    return u;
      4'd6:    return !u;
      4'd7:    return s;
      4'd8:    return !s;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (instr_class)
          3'd0: state_d = FETCH;
          3'd1: state_d = EXEC;
          3'd2: state_d = MEM_RD;
          3'd3: state_d = MEM_WR;
          3'd4: state_d = BRANCH;
          3'd5: state_d = HALTED;
          default: begin
            state_d   = HALTED;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC:   state_d = FETCH;
      MEM_RD: if (mem_ready) state_d = FETCH;
      MEM_WR: if (mem_ready) state_d = FETCH;
      BRANCH: state_d = FETCH;
      HALTED: state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    branch_c           = 1'b0;
    pc_enable_c        = 1'b0;
    ir_enable_c        = 1'b0;
    addr_sel_c         = 1'b0;
    c_sel_c            = 1'b0;
    write_reg_enable_c = 1'b0;
    halt_c             = 1'b0;
    write_enable_c     = 1'b0;
    operation_c        = '0;
    case (state_q)
      FETCH: begin
        ir_enable_c = mem_ready;
        pc_enable_c = mem_ready;
      end
      EXEC: begin
        operation_c        = instr_alu_op;
        c_sel_c            = 1'b1;
        write_reg_enable_c = 1'b1;
      end
      MEM_RD: begin
        addr_sel_c         = 1'b1;
        write_reg_enable_c = mem_ready;
      end
      MEM_WR: begin
        addr_sel_c     = 1'b1;
        write_enable_c = 1'b1;
      end
      BRANCH: begin
        branch_c    = cond_taken(instr_cond, zero, neg, unsigned_overflow,
                                 signed_overflow);
        pc_enable_c = branch_c;
      end
      HALTED: halt_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Gate with rst_n so outputs that follow live inputs (mem_ready in FETCH)
  // also drop to 0 while reset is held, not just after the state reset.
  assign branch           = rst_n & branch_c;
  assign pc_enable        = rst_n & pc_enable_c;
  assign ir_enable        = rst_n & ir_enable_c;
  assign addr_sel         = rst_n & addr_sel_c;
  assign c_sel            = rst_n & c_sel_c;
  assign write_reg_enable = rst_n & write_reg_enable_c;
  assign halt             = rst_n & halt_c;
  assign write_enable     = rst_n & write_enable_c;
  assign operation        = operation_c & {OP_W{rst_n}};
  assign illegal          = illegal_q;

`ifdef KS_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != HALTED && cycle_cnt_q != CNT_MAX)
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    if (state_q == DECODE && instr_cnt_q != CNT_MAX)
      instr_cnt_d = instr_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instr_count = instr_cnt_q;
  assign cycle_count = cycle_cnt_q;
`else
  assign instr_count = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_ks_control_mc.sv
// Directed self-checking bench for ks_control_mc (CNT_W=4 to reach saturation).
module tb_ks_control_mc;

`ifdef KS_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector: {branch,pc_en,ir_en,addr_sel,c_sel,wre,halt,we,illegal}
  localparam logic [31:0] NONE = 32'h000;
  localparam logic [31:0] F_OK = 32'b011000000;
  localparam logic [31:0] EX   = 32'b000011000;
  localparam logic [31:0] WR   = 32'b000100010;
  localparam logic [31:0] RDW  = 32'b000100000;
  localparam logic [31:0] RD   = 32'b000101000;
  localparam logic [31:0] TK   = 32'b110000000;
  localparam logic [31:0] HLI  = 32'b000000101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] instr_class = 3'd0;
  logic [1:0] instr_alu_op = 2'd0;
  logic [3:0] instr_cond = 4'd0;
  logic       zero = 1'b0, neg = 1'b0, unsigned_overflow = 1'b0, signed_overflow = 1'b0;
  logic       mem_ready = 1'b0;
  logic       branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable;
  logic [1:0] operation;
  logic       halt, write_enable, illegal;
  logic [3:0] instr_count, cycle_count;
  logic [31:0] ctrl_v;

  int n_checks = 0;
  int n_fail   = 0;

  ks_control_mc #(.OP_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_class(instr_class),
    .instr_alu_op(instr_alu_op), .instr_cond(instr_cond), .zero(zero),
    .neg(neg), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .mem_ready(mem_ready),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .write_reg_enable(write_reg_enable),
    .operation(operation), .halt(halt), .write_enable(write_enable),
    .illegal(illegal), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  assign ctrl_v = {23'd0, branch, pc_enable, ir_enable, addr_sel, c_sel,
                   write_reg_enable, halt, write_enable, illegal};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, then check the Moore outputs.
  task automatic go(input string tag, input logic [2:0] cls, input logic mr,
                    input logic [31:0] exp, input logic [31:0] eop);
    @(negedge clk);
    instr_class = cls;
    mem_ready   = mr;
    #1;
    check(tag, ctrl_v, exp);
    check({tag, "_op"}, {30'd0, operation}, eop);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    instr_class = 3'd0;
    #1;
    check("rst_ctrl", ctrl_v, NONE);
    check("rst_op", {30'd0, operation}, 32'd0);
    check("rst_icnt", {28'd0, instr_count}, 32'd0);
    check("rst_ccnt", {28'd0, cycle_count}, 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // ALU, NOP, STORE with 3 waits, FETCH wait, LOAD with 1 wait
    instr_alu_op = 2'd2;
    go("alu_f", 3'd1, 1'b1, F_OK, 0);
    go("alu_d", 3'd1, 1'b1, NONE, 0);
    go("alu_ex", 3'd1, 1'b1, EX, 2);
    go("alu_f2", 3'd0, 1'b1, F_OK, 0);
    go("nop_d", 3'd0, 1'b1, NONE, 0);
    go("st_f", 3'd3, 1'b1, F_OK, 0);
    go("st_d", 3'd3, 1'b1, NONE, 0);
    for (int i = 0; i < 3; i++) go("st_wait", 3'd3, 1'b0, WR, 0);
    go("st_done", 3'd3, 1'b1, WR, 0);
    go("fw_wait", 3'd2, 1'b0, NONE, 0);
    go("ld_f", 3'd2, 1'b1, F_OK, 0);
    go("ld_d", 3'd2, 1'b1, NONE, 0);
    go("ld_wait", 3'd2, 1'b0, RDW, 0);
    go("ld_done", 3'd2, 1'b1, RD, 0);

    // Branches: zero taken, zero not taken, always taken
    instr_cond = 4'd1;
    zero = 1'b1;
    go("br_f", 3'd4, 1'b1, F_OK, 0);
    go("br_d", 3'd4, 1'b1, NONE, 0);
    go("br_tk", 3'd4, 1'b1, TK, 0);
    go("br_f2", 3'd4, 1'b1, F_OK, 0);
    zero = 1'b0;
    go("br_d2", 3'd4, 1'b1, NONE, 0);
    go("br_nt", 3'd4, 1'b1, NONE, 0);
    go("br_f3", 3'd4, 1'b1, F_OK, 0);
    instr_cond = 4'd0;
    go("br_d3", 3'd4, 1'b1, NONE, 0);
    go("br_alw", 3'd4, 1'b1, TK, 0);

    // Illegal class: sticky halt, then asynchronous reset
    go("ill_f", 3'd7, 1'b1, F_OK, 0);
    go("ill_d", 3'd7, 1'b1, NONE, 0);
    for (int i = 0; i < 10; i++) go("ill_hold", 3'd1, 1'(i % 2), HLI, 0);
    #2 rst_n = 1'b0;
    #1 check("ill_rst", ctrl_v, NONE);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // Reset during a pending write
    go("wr_f", 3'd3, 1'b1, F_OK, 0);
    go("wr_d", 3'd3, 1'b1, NONE, 0);
    go("wr_w", 3'd3, 1'b0, WR, 0);
    #2 rst_n = 1'b0;
    #1 check("wr_rst_we", {31'd0, write_enable}, 0);
    check("wr_rst_ctrl", ctrl_v, NONE);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    go("wr_rel_f", 3'd0, 1'b1, F_OK, 0);

    // Counters: 20 NOPs from a fresh reset
    do_reset();
    go("c_f0", 3'd0, 1'b1, F_OK, 0);
    check("cnt_c1", {28'd0, cycle_count}, PERF ? 32'd1 : 32'd0);
    go("c_d0", 3'd0, 1'b1, NONE, 0);
    check("cnt_c2", {28'd0, cycle_count}, PERF ? 32'd2 : 32'd0);
    check("cnt_i0", {28'd0, instr_count}, 32'd0);
    go("c_f1", 3'd0, 1'b1, F_OK, 0);
    check("cnt_c3", {28'd0, cycle_count}, PERF ? 32'd3 : 32'd0);
    check("cnt_i1", {28'd0, instr_count}, PERF ? 32'd1 : 32'd0);
    for (int i = 0; i < 19; i++) begin
      go("c_d", 3'd0, 1'b1, NONE, 0);
      go("c_f", 3'd0, 1'b1, F_OK, 0);
    end
    check("cnt_isat", {28'd0, instr_count}, PERF ? 32'd15 : 32'd0);
    check("cnt_csat", {28'd0, cycle_count}, PERF ? 32'd15 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
